// File: rtl/lsu_ctrl.sv
`default_nettype none
// lsu_ctrl: routes AGU load/store commands to ITCM/DTCM, tracks them in order, aligns load writeback data.
// Rev 1.0 -- define LSU_MISALIGN_EXCP_EN to fault misaligned accesses instead of aligning them.
module lsu_ctrl #(
   parameter int XLEN    = 32,
   parameter int ITAG_W  = 2,
   parameter int OSTD    = 2,
   parameter int RGN_LSB = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              lsu_active,
   input  logic [XLEN-1:0]   itcm_region_indic,
   input  logic [XLEN-1:0]   dtcm_region_indic,
   input  logic              agu_cmd_valid,
   output logic              agu_cmd_ready,
   input  logic [XLEN-1:0]   agu_cmd_addr,
   input  logic [XLEN-1:0]   agu_cmd_wdata,
   input  logic              agu_cmd_read,
   input  logic [1:0]        agu_cmd_size,
   input  logic              agu_cmd_usign,
   input  logic [ITAG_W-1:0] agu_cmd_itag,
   output logic              itcm_cmd_valid,
   input  logic              itcm_cmd_ready,
   output logic [XLEN-1:0]   itcm_cmd_addr,
   output logic              itcm_cmd_read,
   output logic [XLEN-1:0]   itcm_cmd_wdata,
   output logic [XLEN/8-1:0] itcm_cmd_wmask,
   input  logic              itcm_rsp_valid,
   output logic              itcm_rsp_ready,
   input  logic [XLEN-1:0]   itcm_rsp_rdata,
   input  logic              itcm_rsp_err,
   output logic              dtcm_cmd_valid,
   input  logic              dtcm_cmd_ready,
   output logic [XLEN-1:0]   dtcm_cmd_addr,
   output logic              dtcm_cmd_read,
   output logic [XLEN-1:0]   dtcm_cmd_wdata,
   output logic [XLEN/8-1:0] dtcm_cmd_wmask,
   input  logic              dtcm_rsp_valid,
   output logic              dtcm_rsp_ready,
   input  logic [XLEN-1:0]   dtcm_rsp_rdata,
   input  logic              dtcm_rsp_err,
   output logic              lsu_o_valid,
   input  logic              lsu_o_ready,
   output logic [XLEN-1:0]   lsu_o_wbck_data,
   output logic [ITAG_W-1:0] lsu_o_wbck_itag,
   output logic              lsu_o_wbck_err
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int PW   = (OSTD > 1) ? $clog2(OSTD) : 1;
   localparam int CW   = $clog2(OSTD + 1);
   localparam int SW   = $clog2(XLEN);
   localparam logic [CW-1:0] FULL_CNT = CW'(OSTD);
   localparam logic [SW-1:0] SH_B = SW'(XLEN - 8);
   localparam logic [SW-1:0] SH_H = SW'(XLEN - 16);
   localparam logic [SW-1:0] SH_W = SW'(XLEN - 32);

   logic              hit_itcm, hit_dtcm, dec_fault, cmd_fault, cmd_tgt, tgt_ready;
   logic              full, block, cmd_go, push, pop, push_i, push_d, pop_i, pop_d, nonempty;
   logic [1:0]        eff_size;
   logic [OFFW-1:0]   off, lane_mask, off_al;
   logic [XLEN-1:0]   bus_addr, bus_wdata;
   logic [NB-1:0]     bus_wmask;
   logic              unused_rgn;

   logic [ITAG_W-1:0] e_itag  [OSTD];
   logic              e_read  [OSTD];
   logic              e_usign [OSTD];
   logic              e_tgt   [OSTD];
   logic              e_fault [OSTD];
   logic [1:0]        e_size  [OSTD];
   logic [OFFW-1:0]   e_off   [OSTD];
   logic [PW-1:0]     wptr, rptr;
   logic [CW-1:0]     count, n_itcm, n_dtcm;

   logic              h_tgt, h_fault, h_read, h_usign;
   logic [1:0]        h_size;
   logic [OFFW-1:0]   h_off;
   logic [XLEN-1:0]   rsp_rdata, shifted, left, ld_data;
   logic signed [XLEN-1:0] sext;
   logic [SW-1:0]     sh;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (int'(p) == OSTD - 1) ? '0 : p + 1'b1;
   endfunction

   assign unused_rgn = ^{itcm_region_indic[RGN_LSB-1:0], dtcm_region_indic[RGN_LSB-1:0]};

   assign hit_itcm  = agu_cmd_addr[XLEN-1:RGN_LSB] == itcm_region_indic[XLEN-1:RGN_LSB];
   assign hit_dtcm  = agu_cmd_addr[XLEN-1:RGN_LSB] == dtcm_region_indic[XLEN-1:RGN_LSB];
   assign dec_fault = !hit_itcm && !hit_dtcm;
   assign cmd_tgt   = hit_itcm;
   // A 32-bit datapath has no dword lanes, so dword collapses to word.
   assign eff_size  = (XLEN == 32 && agu_cmd_size == 2'd3) ? 2'd2 : agu_cmd_size;
   assign off       = agu_cmd_addr[OFFW-1:0];

   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < OFFW; b++)
         if (b < int'(eff_size)) lane_mask[b] = 1'b1;
   end

   assign off_al = off & ~lane_mask;

`ifdef LSU_MISALIGN_EXCP_EN
   assign cmd_fault = dec_fault | (|(off & lane_mask));
`else
   assign cmd_fault = dec_fault;
`endif

   // Only one target may have entries in flight so responses cannot overtake each other.
   assign block     = !cmd_fault && (cmd_tgt ? (n_dtcm != '0) : (n_itcm != '0));
   assign tgt_ready = cmd_tgt ? itcm_cmd_ready : dtcm_cmd_ready;
   assign full      = count == FULL_CNT;
   assign agu_cmd_ready = !full && (cmd_fault || tgt_ready) && !block;
   assign cmd_go    = agu_cmd_valid && !full && !block && !cmd_fault;
   assign bus_addr  = {agu_cmd_addr[XLEN-1:OFFW], off_al};

   always_comb begin
      bus_wdata = '0;
      bus_wmask = '0;
      for (int i = 0; i < NB; i++) begin
         bus_wdata[i*8 +: 8] = agu_cmd_wdata[int'(OFFW'(i) & lane_mask)*8 +: 8];
         bus_wmask[i]        = (OFFW'(i) & ~lane_mask) == off_al;
      end
   end

   assign itcm_cmd_valid = cmd_go && cmd_tgt;
   assign dtcm_cmd_valid = cmd_go && !cmd_tgt;
   assign itcm_cmd_addr  = bus_addr;
   assign dtcm_cmd_addr  = bus_addr;
   assign itcm_cmd_read  = agu_cmd_read;
   assign dtcm_cmd_read  = agu_cmd_read;
   assign itcm_cmd_wdata = bus_wdata;
   assign dtcm_cmd_wdata = bus_wdata;
   assign itcm_cmd_wmask = bus_wmask;
   assign dtcm_cmd_wmask = bus_wmask;

   assign push     = agu_cmd_valid && agu_cmd_ready;
   assign pop      = lsu_o_valid && lsu_o_ready;
   assign push_i   = push && !cmd_fault && cmd_tgt;
   assign push_d   = push && !cmd_fault && !cmd_tgt;
   assign pop_i    = pop && !h_fault && h_tgt;
   assign pop_d    = pop && !h_fault && !h_tgt;
   assign nonempty = count != '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         n_itcm <= '0;
         n_dtcm <= '0;
      end else begin
         if (push) wptr <= nxt(wptr);
         if (pop)  rptr <= nxt(rptr);
         count  <= count + CW'(push) - CW'(pop);
         n_itcm <= n_itcm + CW'(push_i) - CW'(pop_i);
         n_dtcm <= n_dtcm + CW'(push_d) - CW'(pop_d);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         e_itag[wptr]  <= agu_cmd_itag;
         e_read[wptr]  <= agu_cmd_read;
         e_usign[wptr] <= agu_cmd_usign;
         e_tgt[wptr]   <= cmd_tgt;
         e_fault[wptr] <= cmd_fault;
         e_size[wptr]  <= eff_size;
         e_off[wptr]   <= off_al;
      end
   end

   assign h_tgt   = e_tgt[rptr];
   assign h_fault = e_fault[rptr];
   assign h_read  = e_read[rptr];
   assign h_usign = e_usign[rptr];
   assign h_size  = e_size[rptr];
   assign h_off   = e_off[rptr];

   // Load alignment: shift the lane down, then left-justify and shift back to extend.
   assign rsp_rdata = h_tgt ? itcm_rsp_rdata : dtcm_rsp_rdata;
   assign shifted   = rsp_rdata >> {h_off, 3'b000};

   always_comb begin
      case (h_size)
         2'd0:    sh = SH_B;
         2'd1:    sh = SH_H;
         2'd2:    sh = SH_W;
         default: sh = '0;
      endcase
   end

   assign left    = shifted << sh;
   assign sext    = $signed(left) >>> sh;
   assign ld_data = h_usign ? (left >> sh) : sext;

   always_comb begin
      lsu_o_valid     = 1'b0;
      lsu_o_wbck_data = '0;
      lsu_o_wbck_err  = 1'b0;
      itcm_rsp_ready  = 1'b0;
      dtcm_rsp_ready  = 1'b0;
      if (nonempty) begin
         if (h_fault) begin
            lsu_o_valid    = 1'b1;
            lsu_o_wbck_err = 1'b1;
         end else begin
            lsu_o_valid     = h_tgt ? itcm_rsp_valid : dtcm_rsp_valid;
            lsu_o_wbck_err  = h_tgt ? itcm_rsp_err : dtcm_rsp_err;
            lsu_o_wbck_data = h_read ? ld_data : '0;
            itcm_rsp_ready  = h_tgt && lsu_o_ready;
            dtcm_rsp_ready  = !h_tgt && lsu_o_ready;
         end
      end
   end

   assign lsu_o_wbck_itag = e_itag[rptr];
   assign lsu_active      = agu_cmd_valid | nonempty;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with simple ITCM/DTCM responders.
// Rev 1.0
module tb_lsu_ctrl;
   localparam logic [31:0] ITCM = 32'h0001_0000;
   localparam logic [31:0] DTCM = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst, lsu_active;
   logic [31:0] itcm_region_indic, dtcm_region_indic;
   logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
   logic [31:0] agu_cmd_addr, agu_cmd_wdata;
   logic [1:0]  agu_cmd_size, agu_cmd_itag;
   logic        itcm_cmd_valid, itcm_cmd_ready, itcm_cmd_read;
   logic [31:0] itcm_cmd_addr, itcm_cmd_wdata;
   logic [3:0]  itcm_cmd_wmask;
   logic        itcm_rsp_valid, itcm_rsp_ready, itcm_rsp_err;
   logic [31:0] itcm_rsp_rdata;
   logic        dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
   logic [31:0] dtcm_cmd_addr, dtcm_cmd_wdata;
   logic [3:0]  dtcm_cmd_wmask;
   logic        dtcm_rsp_valid, dtcm_rsp_ready, dtcm_rsp_err;
   logic [31:0] dtcm_rsp_rdata;
   logic        lsu_o_valid, lsu_o_ready, lsu_o_wbck_err;
   logic [31:0] lsu_o_wbck_data;
   logic [1:0]  lsu_o_wbck_itag;

   typedef struct {
      logic [1:0]  itag;
      logic [31:0] data;
      logic        err;
   } wb_t;

   wb_t         sbq[$];
   logic [31:0] dq_i[$], rq_i[$], dq_d[$], rq_d[$];
   logic        hold_i, hold_d, flush_d;
   int          n_chk = 0;
   int          n_pass = 0;

   lsu_ctrl dut (
      .clk(clk), .rst(rst), .lsu_active(lsu_active),
      .itcm_region_indic(itcm_region_indic), .dtcm_region_indic(dtcm_region_indic),
      .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_addr(agu_cmd_addr),
      .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_read(agu_cmd_read), .agu_cmd_size(agu_cmd_size),
      .agu_cmd_usign(agu_cmd_usign), .agu_cmd_itag(agu_cmd_itag),
      .itcm_cmd_valid(itcm_cmd_valid), .itcm_cmd_ready(itcm_cmd_ready), .itcm_cmd_addr(itcm_cmd_addr),
      .itcm_cmd_read(itcm_cmd_read), .itcm_cmd_wdata(itcm_cmd_wdata), .itcm_cmd_wmask(itcm_cmd_wmask),
      .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_ready(itcm_rsp_ready), .itcm_rsp_rdata(itcm_rsp_rdata),
      .itcm_rsp_err(itcm_rsp_err),
      .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_addr(dtcm_cmd_addr),
      .dtcm_cmd_read(dtcm_cmd_read), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
      .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
      .dtcm_rsp_err(dtcm_rsp_err),
      .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_data(lsu_o_wbck_data),
      .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_wbck_err(lsu_o_wbck_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // tgt: 0 = DTCM, 1 = ITCM, 2 = no bus access (fault)
   task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                        input logic [1:0] sz, input logic us, input logic [1:0] tag, input int tgt,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_mask,
                        input logic [31:0] rdata, input logic [31:0] e_data, input logic e_err);
      int n;
      n = 0;
      agu_cmd_valid = 1'b1; agu_cmd_addr = addr; agu_cmd_wdata = wdata; agu_cmd_read = rd;
      agu_cmd_size = sz; agu_cmd_usign = us; agu_cmd_itag = tag;
      @(negedge clk);
      while (!agu_cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("agu_ready", agu_cmd_ready, 1);
      if (tgt == 2) begin
         check("no_bus", {itcm_cmd_valid, dtcm_cmd_valid}, 0);
      end else begin
         check("cmd_valid", {itcm_cmd_valid, dtcm_cmd_valid}, (tgt == 1) ? 2 : 1);
         check("cmd_addr", (tgt == 1) ? itcm_cmd_addr : dtcm_cmd_addr, e_addr);
         check("cmd_read", (tgt == 1) ? itcm_cmd_read : dtcm_cmd_read, rd);
         check("cmd_wmask", (tgt == 1) ? itcm_cmd_wmask : dtcm_cmd_wmask, e_mask);
         if (!rd) check("cmd_wdata", (tgt == 1) ? itcm_cmd_wdata : dtcm_cmd_wdata, e_wdata);
         if (tgt == 1) dq_i.push_back(rdata);
         else          dq_d.push_back(rdata);
      end
      sbq.push_back('{itag: tag, data: e_data, err: e_err});
      @(posedge clk); #1;
      agu_cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      check("drain", sbq.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic offer(input logic [31:0] addr, input logic [1:0] tag);
      agu_cmd_valid = 1'b1; agu_cmd_addr = addr; agu_cmd_read = 1'b1;
      agu_cmd_size = 2'd2; agu_cmd_usign = 1'b0; agu_cmd_itag = tag;
   endtask

   // DTCM responder
   initial begin
      bit f_cmd, f_rsp;
      dtcm_rsp_valid = 1'b0; dtcm_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         f_cmd = dtcm_cmd_valid && dtcm_cmd_ready;
         f_rsp = dtcm_rsp_valid && dtcm_rsp_ready;
         @(posedge clk); #1;
         if (f_rsp && rq_d.size() != 0) void'(rq_d.pop_front());
         if (f_cmd && dq_d.size() != 0) rq_d.push_back(dq_d.pop_front());
         if (flush_d) rq_d.delete();
         dtcm_rsp_valid = !hold_d && rq_d.size() != 0;
         dtcm_rsp_rdata = (rq_d.size() != 0) ? rq_d[0] : '0;
      end
   end

   // ITCM responder
   initial begin
      bit f_cmd, f_rsp;
      itcm_rsp_valid = 1'b0; itcm_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         f_cmd = itcm_cmd_valid && itcm_cmd_ready;
         f_rsp = itcm_rsp_valid && itcm_rsp_ready;
         @(posedge clk); #1;
         if (f_rsp && rq_i.size() != 0) void'(rq_i.pop_front());
         if (f_cmd && dq_i.size() != 0) rq_i.push_back(dq_i.pop_front());
         itcm_rsp_valid = !hold_i && rq_i.size() != 0;
         itcm_rsp_rdata = (rq_i.size() != 0) ? rq_i[0] : '0;
      end
   end

   // Writeback scoreboard
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (lsu_o_valid && lsu_o_ready) begin
            if (sbq.size() == 0) begin
               check("wb_unexpected", 1, 0);
            end else begin
               e = sbq.pop_front();
               check("wb_itag", lsu_o_wbck_itag, e.itag);
               check("wb_data", lsu_o_wbck_data, e.data);
               check("wb_err", lsu_o_wbck_err, e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_wdata = '0; agu_cmd_read = 1'b0;
      agu_cmd_size = '0; agu_cmd_usign = 1'b0; agu_cmd_itag = '0; lsu_o_ready = 1'b1;
      itcm_cmd_ready = 1'b1; dtcm_cmd_ready = 1'b1; itcm_rsp_err = 1'b0; dtcm_rsp_err = 1'b0;
      hold_i = 1'b0; hold_d = 1'b0; flush_d = 1'b0;
      itcm_region_indic = ITCM; dtcm_region_indic = DTCM;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_o_valid", lsu_o_valid, 0);
      check("rst_rsp_ready", {itcm_rsp_ready, dtcm_rsp_ready}, 0);
      check("rst_active", lsu_active, 0);
      check("rst_agu_ready", agu_cmd_ready, 1);
      #1 agu_cmd_valid = 1'b1;
      #1 check("rst_active_valid", lsu_active, 1);
      agu_cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Byte load, signed; first stalled by DTCM cmd_ready
      dtcm_cmd_ready = 1'b0;
      offer(DTCM + 32'd3, 2'd0);
      agu_cmd_size = 2'd0;
      @(negedge clk);
      check("stall_tgt_ready", agu_cmd_ready, 0);
      check("stall_cmd_valid", dtcm_cmd_valid, 1);
      @(posedge clk); #1;
      dtcm_cmd_ready = 1'b1;
      issue(DTCM + 32'd3, 32'h0, 1, 2'd0, 0, 2'd0, 0, DTCM + 32'd3, 32'h0, 4'h8,
            32'h80FF_FFFF, 32'hFFFF_FF80, 0);
      // Half store to ITCM behind the DTCM load
      issue(ITCM + 32'd2, 32'h1234, 0, 2'd1, 0, 2'd1, 1, ITCM + 32'd2, 32'h1234_1234, 4'hC,
            32'hCAFE_F00D, 32'h0, 0);
      drain();

      // Decode fault held until lsu_o_ready
      lsu_o_ready = 1'b0;
      issue(32'h0005_0000, 32'h0, 1, 2'd2, 0, 2'd2, 2, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
      @(negedge clk);
      check("fault_valid", lsu_o_valid, 1);
      check("fault_rsp_ready", {itcm_rsp_ready, dtcm_rsp_ready}, 0);
      @(posedge clk); #1;
      lsu_o_ready = 1'b1;
      drain();

      // Sign/zero extension, dword-as-word, byte store, bus error
      issue(DTCM + 32'd2, 32'h0, 1, 2'd1, 1, 2'd3, 0, DTCM + 32'd2, 32'h0, 4'hC,
            32'hBEEF_1234, 32'h0000_BEEF, 0);
      issue(DTCM + 32'd2, 32'h0, 1, 2'd1, 0, 2'd0, 0, DTCM + 32'd2, 32'h0, 4'hC,
            32'hBEEF_1234, 32'hFFFF_BEEF, 0);
      issue(DTCM + 32'd1, 32'h0000_00A5, 0, 2'd0, 0, 2'd1, 0, DTCM + 32'd1, 32'hA5A5_A5A5, 4'h2,
            32'h1111_2222, 32'h0, 0);
      drain();
      issue(ITCM + 32'd4, 32'h0, 1, 2'd3, 0, 2'd2, 1, ITCM + 32'd4, 32'h0, 4'hF,
            32'h89AB_CDEF, 32'h89AB_CDEF, 0);
      issue(ITCM + 32'd1, 32'h0, 1, 2'd0, 1, 2'd3, 1, ITCM + 32'd1, 32'h0, 4'h2,
            32'h0000_9900, 32'h0000_0099, 0);
      drain();
      dtcm_rsp_err = 1'b1;
      issue(DTCM + 32'd8, 32'h0, 1, 2'd2, 0, 2'd0, 0, DTCM + 32'd8, 32'h0, 4'hF,
            32'h55AA_55AA, 32'h55AA_55AA, 1);
      drain();
      dtcm_rsp_err = 1'b0;

      // Outstanding limit, in-order return
      hold_d = 1'b1;
      issue(DTCM + 32'h10, 32'h0, 1, 2'd2, 0, 2'd0, 0, DTCM + 32'h10, 32'h0, 4'hF,
            32'h1111_1111, 32'h1111_1111, 0);
      issue(DTCM + 32'h14, 32'h0, 1, 2'd2, 0, 2'd1, 0, DTCM + 32'h14, 32'h0, 4'hF,
            32'h2222_2222, 32'h2222_2222, 0);
      offer(DTCM + 32'h18, 2'd2);
      repeat (3) begin
         @(negedge clk);
         check("full_agu_ready", agu_cmd_ready, 0);
         check("full_cmd_valid", dtcm_cmd_valid, 0);
         check("full_o_valid", lsu_o_valid, 0);
         check("full_active", lsu_active, 1);
      end
      @(posedge clk); #1;
      hold_d = 1'b0;
      issue(DTCM + 32'h18, 32'h0, 1, 2'd2, 0, 2'd2, 0, DTCM + 32'h18, 32'h0, 4'hF,
            32'h3333_3333, 32'h3333_3333, 0);
      drain();

      // Target switch blocked while DTCM load outstanding
      hold_d = 1'b1;
      issue(DTCM + 32'h20, 32'h0, 1, 2'd2, 0, 2'd3, 0, DTCM + 32'h20, 32'h0, 4'hF,
            32'h4444_4444, 32'h4444_4444, 0);
      offer(ITCM + 32'h20, 2'd0);
      repeat (3) begin
         @(negedge clk);
         check("switch_itcm_valid", itcm_cmd_valid, 0);
         check("switch_agu_ready", agu_cmd_ready, 0);
      end
      @(posedge clk); #1;
      hold_d = 1'b0;
      issue(ITCM + 32'h20, 32'h0, 1, 2'd2, 0, 2'd0, 1, ITCM + 32'h20, 32'h0, 4'hF,
            32'h5555_5555, 32'h5555_5555, 0);
      drain();

      // Misaligned word load
`ifdef LSU_MISALIGN_EXCP_EN
      issue(DTCM + 32'd1, 32'h0, 1, 2'd2, 0, 2'd1, 2, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
`else
      issue(DTCM + 32'd1, 32'h0, 1, 2'd2, 0, 2'd1, 0, DTCM, 32'h0, 4'hF,
            32'h6677_8899, 32'h6677_8899, 0);
`endif
      drain();

      // Both regions hit: ITCM wins
      dtcm_region_indic = ITCM;
      issue(ITCM + 32'h30, 32'h0, 1, 2'd2, 0, 2'd2, 1, ITCM + 32'h30, 32'h0, 4'hF,
            32'h0BAD_CAFE, 32'h0BAD_CAFE, 0);
      drain();
      dtcm_region_indic = DTCM;

      // Reset with a load in flight; the late response must not be accepted
      hold_d = 1'b1;
      issue(DTCM + 32'h40, 32'h0, 1, 2'd2, 0, 2'd1, 0, DTCM + 32'h40, 32'h0, 4'hF,
            32'h7777_7777, 32'h7777_7777, 0);
      rst = 1'b1;
      sbq.delete();
      @(posedge clk); #1;
      hold_d = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("late_rsp_valid_seen", dtcm_rsp_valid, 1);
      check("late_rsp_ready", dtcm_rsp_ready, 0);
      check("late_o_valid", lsu_o_valid, 0);
      check("late_active", lsu_active, 0);
      @(posedge clk); #1;
      flush_d = 1'b1;
      @(posedge clk); #1;
      flush_d = 1'b0;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
